// File: rtl/pi_estimate_accumulator_pkg.sv
// Shared definitions for the Monte Carlo pi simulator: datapath widths,
// circle geometry and the accumulator state encoding.
package pi_sim_pkg;

  localparam int unsigned CNT_W     = 20;
  localparam int unsigned FRAC_BITS = 12;
  localparam int unsigned PI_W      = FRAC_BITS + 3;
  localparam int unsigned COORD_W   = 16;

  // Largest coordinate squared; a point is inside when x^2 + y^2 <= this.
  localparam logic [2*COORD_W-1:0] CIRCLE_RADIUS_SQUARED = 32'hFFFE_0001;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DIVIDE = 2'd2,
    S_DONE   = 2'd3
  } pi_state_e;

endpackage

// File: rtl/pi_estimate_accumulator_divider.sv
// Restoring serial divider producing Q_W quotient bits MSB first, one per cycle.
// The caller guarantees the true quotient fits in Q_W bits.
module serial_divider #(
  parameter int unsigned NUM_W = 34,
  parameter int unsigned DEN_W = 20,
  parameter int unsigned Q_W   = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] denominator,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient,
  output logic [DEN_W-1:0] remainder
);

  localparam int unsigned CNT_BITS = $clog2(Q_W + 1);

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [DEN_W-1:0]    rem_q, rem_d;
  logic [DEN_W-1:0]    den_q, den_d;
  logic [Q_W-1:0]      sh_q, sh_d;

  logic [DEN_W:0]      trial;
  logic [DEN_W:0]      diff;
  logic                fits;

  always_comb begin
    trial  = {rem_q, sh_q[Q_W-1]};
    diff   = trial - {1'b0, den_q};
    fits   = (trial >= {1'b0, den_q});
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    den_d  = den_q;
    sh_d   = sh_q;
    if (start && !busy_q) begin
      busy_d = 1'b1;
      cnt_d  = CNT_BITS'(Q_W);
      // Upper numerator bits seed the remainder; only Q_W iterations remain.
      rem_d  = DEN_W'(numerator >> Q_W);
      sh_d   = numerator[Q_W-1:0];
      den_d  = denominator;
    end else if (busy_q) begin
      rem_d = fits ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
      sh_d  = {sh_q[Q_W-2:0], fits};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_BITS'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      sh_q   <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      sh_q   <= sh_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = sh_q;
  assign remainder = rem_q;

endmodule

// File: rtl/pi_estimate_accumulator.sv
// Counts accepted samples and inside-circle hits over a batch, then derives
// pi ~= 4*hits/total in unsigned fixed point via a serial divider.
module pi_estimate_accumulator #(
  parameter int unsigned CNT_W      = pi_sim_pkg::CNT_W,
  parameter int unsigned BATCH_SIZE = 65536,
  parameter int unsigned FRAC_BITS  = pi_sim_pkg::FRAC_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop_req,
  input  logic                 sample_valid,
  input  logic                 is_inside,
  output logic                 sample_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     total_count,
  output logic [FRAC_BITS+2:0] pi_est,
  output logic                 result_valid,
  output logic                 done
);

  import pi_sim_pkg::*;

  localparam int unsigned RES_W = FRAC_BITS + 3;
  localparam int unsigned NUM_W = CNT_W + FRAC_BITS + 2;
  localparam logic [CNT_W-1:0] BATCH_LIMIT = CNT_W'(BATCH_SIZE);

  pi_state_e        state_q, state_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [RES_W-1:0] pi_q, pi_d;
  logic             rv_q, rv_d;
  logic             done_q, done_d;

  logic             div_start;
  logic [NUM_W-1:0] div_num;
  logic             div_busy;
  logic             div_done;
  logic [RES_W-1:0] div_quo;
  logic [CNT_W-1:0] div_rem;

  always_comb begin
    state_d   = state_q;
    hit_d     = hit_q;
    total_d   = total_q;
    pi_d      = pi_q;
    rv_d      = rv_q;
    done_d    = 1'b0;
    div_start = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ACCUM;
          hit_d   = '0;
          total_d = '0;
          pi_d    = '0;
          rv_d    = 1'b0;
        end
      end
      S_ACCUM: begin
        if (sample_valid) begin
          total_d = total_q + 1'b1;
          hit_d   = hit_q + CNT_W'(is_inside);
        end
        // Exit decisions use post-update counts so a same-cycle sample is kept.
        if ((total_d == BATCH_LIMIT) || stop_req) begin
          if (total_d == '0) begin
            state_d = S_DONE;
            pi_d    = '0;
            rv_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d   = S_DIVIDE;
            div_start = 1'b1;
          end
        end
      end
      S_DIVIDE: begin
        if (div_done) begin
          state_d = S_DONE;
          pi_d    = div_quo;
          rv_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign div_num = NUM_W'(hit_d) << (FRAC_BITS + 2);

  serial_divider #(
    .NUM_W(NUM_W),
    .DEN_W(CNT_W),
    .Q_W  (RES_W)
  ) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (div_start),
    .numerator  (div_num),
    .denominator(total_d),
    .busy       (div_busy),
    .done       (div_done),
    .quotient   (div_quo),
    .remainder  (div_rem)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      hit_q   <= '0;
      total_q <= '0;
      pi_q    <= '0;
      rv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      total_q <= total_d;
      pi_q    <= pi_d;
      rv_q    <= rv_d;
      done_q  <= done_d;
    end
  end

  assign sample_ready = (state_q == S_ACCUM);
  assign busy         = (state_q == S_ACCUM) || (state_q == S_DIVIDE);
  assign hit_count    = hit_q;
  assign total_count  = total_q;
  assign pi_est       = pi_q;
  assign result_valid = rv_q;
  assign done         = done_q;

  a_divide_active: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == S_DIVIDE) |-> (div_busy || div_done));

  a_rem_bounded: assert property (@(posedge clk) disable iff (!reset_n)
    div_done |-> (div_rem < total_q));

endmodule

// File: tb/tb_pi_estimate_accumulator.sv
// Scoreboard bench for pi_estimate_accumulator with a 16-sample batch:
// stimulus queues expected results, a monitor checks them on each done pulse.
module tb_pi_estimate_accumulator;

  localparam int unsigned CNT_W = 20;
  localparam int unsigned PI_W  = 15;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic             stop_req;
  logic             sample_valid;
  logic             is_inside;
  logic             sample_ready;
  logic             busy;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] total_count;
  logic [PI_W-1:0]  pi_est;
  logic             result_valid;
  logic             done;

  pi_estimate_accumulator #(
    .CNT_W     (CNT_W),
    .BATCH_SIZE(16),
    .FRAC_BITS (12)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop_req    (stop_req),
    .sample_valid(sample_valid),
    .is_inside   (is_inside),
    .sample_ready(sample_ready),
    .busy        (busy),
    .hit_count   (hit_count),
    .total_count (total_count),
    .pi_est      (pi_est),
    .result_valid(result_valid),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hits;
    int total;
    int pi;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pi_est", 32'(pi_est), mon_e.pi);
        check("hit_count", 32'(hit_count), mon_e.hits);
        check("total_count", 32'(total_count), mon_e.total);
        check("result_valid_at_done", 32'(result_valid), 32'd1);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_sample_ready"}, 32'(sample_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_hit_count"}, 32'(hit_count), 32'd0);
    check({tag, "_total_count"}, 32'(total_count), 32'd0);
    check({tag, "_pi_est"}, 32'(pi_est), 32'd0);
    check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic do_start(output int s_cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic send(input int n, input logic [15:0] mask, input bit stop_last);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      is_inside    = mask[i];
      stop_req     = stop_last && (i == n - 1);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    is_inside    = 1'b0;
    stop_req     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        at_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at_cyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int d;
    int d0;
    reset_n      = 1'b0;
    start        = 1'b0;
    stop_req     = 1'b0;
    sample_valid = 1'b0;
    is_inside    = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Full batch, all inside: 4.0
    exp_q.push_back('{hits: 16, total: 16, pi: 16384});
    do_start(s);
    send(16, 16'hFFFF, 1'b0);
    check("divide_busy", 32'(busy), 32'd1);
    check("divide_not_ready", 32'(sample_ready), 32'd0);
    wait_done(64, d);
    check("latency_full_batch", 32'(d - s), 32'd32);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("rv_after_done", 32'(result_valid), 32'd1);
    check("idle_in_done", 32'(busy), 32'd0);

    // Full batch, 12 inside: 3.0; samples offered in DONE are refused
    exp_q.push_back('{hits: 12, total: 16, pi: 12288});
    do_start(s);
    send(16, 16'hF0FF, 1'b0);
    wait_done(64, d);
    @(negedge clk);
    sample_valid = 1'b1;
    is_inside    = 1'b1;
    repeat (3) @(negedge clk);
    check("done_ignores_samples", 32'(total_count), 32'd16);
    check("done_not_ready", 32'(sample_ready), 32'd0);
    check("rv_held", 32'(result_valid), 32'd1);
    check("pi_held", 32'(pi_est), 32'd12288);
    sample_valid = 1'b0;
    is_inside    = 1'b0;

    // 7 samples, 5 inside, early stop; start mid-batch ignored
    exp_q.push_back('{hits: 5, total: 7, pi: 11702});
    do_start(s);
    check("start_clears_rv", 32'(result_valid), 32'd0);
    check("start_clears_pi", 32'(pi_est), 32'd0);
    check("start_clears_total", 32'(total_count), 32'd0);
    send(3, 16'h0007, 1'b0);
    check("live_hits", 32'(hit_count), 32'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_total", 32'(total_count), 32'd3);
    check("start_ignored_busy", 32'(busy), 32'd1);
    send(4, 16'h0003, 1'b0);
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    wait_done(64, d);
    @(negedge clk);

    // stop_req together with the 3rd (inside) sample: 2 hits of 3
    exp_q.push_back('{hits: 2, total: 3, pi: 10922});
    do_start(s);
    send(3, 16'h0005, 1'b1);
    wait_done(64, d);
    @(negedge clk);

    // Empty batch: no divide, done right after stop
    exp_q.push_back('{hits: 0, total: 0, pi: 0});
    do_start(s);
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    wait_done(8, d);
    check("latency_empty_batch", 32'(d - s), 32'd1);
    @(negedge clk);

    // Reset in the middle of the divide aborts everything
    do_start(s);
    send(16, 16'hFFFF, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_divide_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    d0 = n_done;
    @(negedge clk);
    reset_n      = 1'b1;
    sample_valid = 1'b1;
    is_inside    = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_ignores_samples", 32'(total_count), 32'd0);
    check("idle_not_ready", 32'(sample_ready), 32'd0);
    sample_valid = 1'b0;
    is_inside    = 1'b0;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", 32'(n_done - d0), 32'd0);
    check("idle_after_abort", 32'(busy), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
